cache_mem_arbiter: RTL and testbench

//  Shares the single RAM port between the icache and dcache of the pipelined CPU.

---
 rtl/cache_mem_arbiter.sv | 113 +++++++++++
 tb/tb_cache_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the shared RAM port between icache and dcache.
// dcache has fixed priority; a starvation counter bounds icache wait.
module cache_mem_arbiter #(
   parameter int WORD_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              iREN,
   input  logic [WORD_W-1:0] iaddr,
   output logic              iwait,
   output logic [WORD_W-1:0] iload,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [WORD_W-1:0] daddr,
   input  logic [WORD_W-1:0] dstore,
   output logic              dwait,
   output logic [WORD_W-1:0] dload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [WORD_W-1:0] ramaddr,
   output logic [WORD_W-1:0] ramstore,
   input  logic [WORD_W-1:0] ramload,
   input  logic [1:0]        ramstate,
   output logic              arb_err
);

   localparam int CW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);
   localparam logic [1:0] RS_ACCESS = 2'd2;
   localparam logic [1:0] RS_ERROR  = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_D = 2'd1,
      GNT_I = 2'd2
   } state_t;

   state_t        state, nstate;
   logic [CW-1:0] starve_cnt, starve_nxt;
   logic          dreq;

   assign dreq  = dREN | dWEN;
   assign iload = ramload;
   assign dload = ramload;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state      <= IDLE;
         starve_cnt <= '0;
      end else begin
         state      <= nstate;
         starve_cnt <= starve_nxt;
      end
   end

   always_comb begin
      nstate     = state;
      starve_nxt = starve_cnt;
      ramREN     = 1'b0;
      ramWEN     = 1'b0;
      ramaddr    = '0;
      ramstore   = '0;
      iwait      = 1'b1;
      dwait      = 1'b1;
      arb_err    = 1'b0;
      unique case (state)
         IDLE: begin
            if (starve_cnt == SMAX && iREN) begin
               nstate     = GNT_I;
               starve_nxt = '0;
            end else if (dreq) begin
               nstate = GNT_D;
               if (iREN && starve_cnt != SMAX)
                  starve_nxt = starve_cnt + 1'b1;
            end else if (iREN) begin
               nstate     = GNT_I;
               starve_nxt = '0;
            end
         end
         GNT_D: begin
            ramaddr  = daddr;
            ramstore = dstore;
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            if (ramstate == RS_ACCESS) begin
               dwait  = 1'b0;
               nstate = IDLE;
            end else if (ramstate == RS_ERROR) begin
               arb_err = 1'b1;
               nstate  = IDLE;
            end else if (!dreq) begin
               nstate = IDLE;
            end
         end
         GNT_I: begin
            ramaddr = iaddr;
            ramREN  = iREN;
            if (ramstate == RS_ACCESS) begin
               iwait  = 1'b0;
               nstate = IDLE;
            end else if (ramstate == RS_ERROR) begin
               arb_err = 1'b1;
               nstate  = IDLE;
            end else if (!iREN) begin
               nstate = IDLE;
            end
         end
         default: nstate = IDLE;
      endcase
   end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter with a 2-cycle RAM model.
// Stimulus pushes expected completions; a negedge monitor checks them.
module tb_cache_mem_arbiter;

   localparam int LAT = 2;
   localparam logic [1:0] RS_FREE   = 2'd0;
   localparam logic [1:0] RS_BUSY   = 2'd1;
   localparam logic [1:0] RS_ACCESS = 2'd2;
   localparam logic [1:0] RS_ERROR  = 2'd3;
   localparam logic [1:0] K_D = 2'd0;
   localparam logic [1:0] K_I = 2'd1;
   localparam logic [1:0] K_E = 2'd2;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        iREN, dREN, dWEN;
   logic [31:0] iaddr, daddr, dstore;
   logic        iwait, dwait, ramREN, ramWEN, arb_err;
   logic [31:0] iload, dload, ramaddr, ramstore, ramload;
   logic [1:0]  ramstate;

   typedef struct {
      logic [1:0]  kind;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] store;
      logic        ren;
      logic        wen;
      bit          chkd;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   bit          err_mode = 1'b0;
   int          acnt;
   logic [31:0] mem[256];
   bit          wvalid[256];
   logic [7:0]  idx;

   always #5 CLK = ~CLK;

   cache_mem_arbiter #(.WORD_W(32), .STARVE_MAX(4)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
      .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
      .arb_err(arb_err)
   );

   function automatic logic [31:0] rd_init(input logic [31:0] a);
      if (a == 32'h8) return 32'hABCD1234;
      return a * 3 + 32'h1000_0000;
   endfunction

   assign idx = ramaddr[9:2];

   always_comb begin
      ramstate = RS_FREE;
      if (ramREN | ramWEN)
         ramstate = (acnt == LAT - 1) ? (err_mode ? RS_ERROR : RS_ACCESS) : RS_BUSY;
   end

   always_comb ramload = wvalid[idx] ? mem[idx] : rd_init(ramaddr);

   always @(posedge CLK or negedge nRST) begin
      if (!nRST) acnt <= 0;
      else if ((ramREN | ramWEN) && ramstate == RS_BUSY) acnt <= acnt + 1;
      else acnt <= 0;
   end

   always @(posedge CLK) begin
      if (nRST && ramWEN && ramstate == RS_ACCESS) begin
         mem[idx]    <= ramstore;
         wvalid[idx] <= 1'b1;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic push(input logic [1:0] k, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] s, input logic r, input logic w, input bit c);
      exp_t e;
      e.kind = k; e.addr = a; e.data = d; e.store = s;
      e.ren = r; e.wen = w; e.chkd = c;
      q.push_back(e);
   endtask

   always @(negedge CLK) begin
      if (nRST) begin
         chk("wait_excl", 32'(dwait | iwait), 32'd1);
         if (!dwait || !iwait || arb_err) begin
            exp_t e;
            logic [1:0] k;
            k = arb_err ? K_E : (!dwait ? K_D : K_I);
            if (q.size() == 0) begin
               chk("sb_unexpected", 32'(k), 32'hFFFF_FFFF);
            end else begin
               e = q.pop_front();
               chk("sb_kind", 32'(k), 32'(e.kind));
               chk("sb_addr", ramaddr, e.addr);
               chk("sb_ren", 32'(ramREN), 32'(e.ren));
               chk("sb_wen", 32'(ramWEN), 32'(e.wen));
               chk("sb_store", ramstore, e.store);
               if (k == K_E) chk("sb_err_iwait", 32'(iwait), 32'd1);
               if (e.chkd) chk("sb_load", (k == K_D) ? dload : iload, e.data);
            end
         end
      end
   end

   task automatic d_access(input logic r, input logic w, input logic [31:0] a,
                           input logic [31:0] s, input logic [31:0] d, input bit c);
      bit done = 0;
      push(K_D, a, d, s, r & ~w, w, c);
      @(posedge CLK); #1;
      dREN = r; dWEN = w; daddr = a; dstore = s;
      for (int n = 0; n < 40 && !done; n++) begin
         @(negedge CLK);
         if (!dwait) done = 1;
      end
      if (!done) chk("d_timeout", 32'd0, 32'd1);
      @(posedge CLK); #1;
      dREN = 0; dWEN = 0;
   endtask

   initial begin
      bit dseen, iseen, fin;
      int dc, ic, ndone;
      nRST = 0; iREN = 0; dREN = 0; dWEN = 0;
      iaddr = 0; daddr = 0; dstore = 0;
      #3;
      chk("rst_ramREN", 32'(ramREN), 32'd0);
      chk("rst_ramWEN", 32'(ramWEN), 32'd0);
      chk("rst_ramaddr", ramaddr, 32'd0);
      chk("rst_ramstore", ramstore, 32'd0);
      chk("rst_iwait", 32'(iwait), 32'd1);
      chk("rst_dwait", 32'(dwait), 32'd1);
      chk("rst_arb_err", 32'(arb_err), 32'd0);
      repeat (2) @(negedge CLK);
      nRST = 1;

      // 1: single dcache read with exact cycle timing
      push(K_D, 32'h8, 32'hABCD1234, 32'h0, 1, 0, 1);
      @(posedge CLK); #1;
      dREN = 1; daddr = 32'h8;
      @(negedge CLK);
      chk("t1_idle_ren", 32'(ramREN), 32'd0);
      @(negedge CLK);
      chk("t1_g1_ren", 32'(ramREN), 32'd1);
      chk("t1_g1_addr", ramaddr, 32'h8);
      chk("t1_g1_dwait", 32'(dwait), 32'd1);
      @(negedge CLK);
      chk("t1_g2_dwait", 32'(dwait), 32'd0);
      @(posedge CLK); #1;
      dREN = 0;
      @(negedge CLK);
      chk("t1_after_dwait", 32'(dwait), 32'd1);
      chk("t1_after_ren", 32'(ramREN), 32'd0);

      // 2: simultaneous requests, dcache first, icache after turnaround
      push(K_D, 32'h10, 32'h1000_0030, 32'h0, 1, 0, 1);
      push(K_I, 32'h14, 32'h1000_003C, 32'h0, 1, 0, 1);
      dseen = 0; iseen = 0; dc = 0; ic = 0;
      @(posedge CLK); #1;
      dREN = 1; daddr = 32'h10; iREN = 1; iaddr = 32'h14;
      for (int n = 0; n < 40 && !iseen; n++) begin
         if (n > 0) begin
            @(posedge CLK); #1;
            if (dseen) dREN = 0;
         end
         @(negedge CLK);
         if (!dwait && !dseen) begin dseen = 1; dc = n; end
         if (!iwait) begin iseen = 1; ic = n; end
         else if (!dseen) chk("t2_iwait_held", 32'(iwait), 32'd1);
      end
      chk("t2_order", 32'({dseen, iseen}), 32'd3);
      chk("t2_gap", 32'(ic - dc), 32'd3);
      @(posedge CLK); #1;
      iREN = 0; dREN = 0;

      // 3: starvation bound
      for (int k = 0; k < 4; k++) push(K_D, 32'h100, 32'h1000_0300, 32'h0, 1, 0, 1);
      push(K_I, 32'h24, 32'h1000_006C, 32'h0, 1, 0, 1);
      ndone = 0; fin = 0;
      @(posedge CLK); #1;
      dREN = 1; daddr = 32'h100; iREN = 1; iaddr = 32'h24;
      for (int n = 0; n < 80 && !fin; n++) begin
         @(negedge CLK);
         if (!dwait) ndone++;
         if (!iwait) fin = 1;
      end
      chk("t3_igrant", 32'(fin), 32'd1);
      chk("t3_dgrants", 32'(ndone), 32'd4);
      @(posedge CLK); #1;
      dREN = 0; iREN = 0;
      @(negedge CLK);
      chk("t3_starve_clr", 32'(dut.starve_cnt), 32'd0);

      // 4: write wins over read, then read back
      d_access(1, 1, 32'h40, 32'hDEADBEEF, 32'h0, 0);
      d_access(1, 0, 32'h40, 32'h0, 32'hDEADBEEF, 1);

      // 5: ERROR during icache grant, retried
      push(K_E, 32'h20, 32'h0, 32'h0, 1, 0, 0);
      push(K_I, 32'h20, 32'h1000_0060, 32'h0, 1, 0, 1);
      err_mode = 1; fin = 0;
      @(posedge CLK); #1;
      iREN = 1; iaddr = 32'h20;
      for (int n = 0; n < 40 && !fin; n++) begin
         @(negedge CLK);
         if (arb_err) fin = 1;
      end
      chk("t5_err_seen", 32'(fin), 32'd1);
      @(posedge CLK); #1;
      err_mode = 0;
      chk("t5_err_pulse", 32'(arb_err), 32'd0);
      fin = 0;
      for (int n = 0; n < 40 && !fin; n++) begin
         @(negedge CLK);
         if (!iwait) fin = 1;
      end
      chk("t5_retry_done", 32'(fin), 32'd1);
      @(posedge CLK); #1;
      iREN = 0;

      // 6: reset during a busy dcache grant, then retry
      push(K_D, 32'h80, 32'h1000_0180, 32'h0, 1, 0, 1);
      @(posedge CLK); #1;
      dREN = 1; daddr = 32'h80;
      @(negedge CLK);
      @(negedge CLK);
      chk("t6_busy_ren", 32'(ramREN), 32'd1);
      #2 nRST = 0;
      #1;
      chk("t6_rst_ren", 32'(ramREN), 32'd0);
      chk("t6_rst_addr", ramaddr, 32'd0);
      chk("t6_rst_dwait", 32'(dwait), 32'd1);
      chk("t6_rst_iwait", 32'(iwait), 32'd1);
      chk("t6_rst_err", 32'(arb_err), 32'd0);
      @(posedge CLK); #1;
      nRST = 1;
      fin = 0;
      for (int n = 0; n < 40 && !fin; n++) begin
         @(negedge CLK);
         if (!dwait) fin = 1;
      end
      chk("t6_retry_done", 32'(fin), 32'd1);
      @(posedge CLK); #1;
      dREN = 0;
      repeat (3) @(negedge CLK);
      chk("sb_drained", 32'(q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
